// File: rtl/handshake_pkg.sv
// Shared state encoding and defaults for the 4-phase channel arbiter.
package handshake_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// Reset-to-0 flop chain bringing an asynchronous level into the clk domain.
// Latency: `stages` edges; no flow control, the output is a plain level.
module sync_ff #(
  parameter int stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [stages-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[stages-2:0], d};
    end
  end

  assign q = sync_q[stages-1];

endmodule

// File: rtl/handshake_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack channel among `size` requesters.
// Grant one edge after a request is seen; requesters hold req until done. Optional abort: HS_ARB_TIMEOUT_EN.
module handshake_arbiter
  import handshake_pkg::*;
#(
  parameter int size        = 2,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT     = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [size-1:0] req_vec,
  output logic [size-1:0] grant_vec,
  output logic [size-1:0] done_vec,
  output logic            busy,
  output logic            ch_req,
  input  logic            ch_ack
`ifdef HS_ARB_TIMEOUT_EN
  ,
  output logic            err_timeout
`endif
);

  localparam int IDX_W = $clog2(size);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(size - 1);

  if (size < 2 || SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_params
    $error("handshake_arbiter: size and SYNC_STAGES must be >= 2, TIMEOUT >= 1");
  end

  arb_state_t       state_q, state_d;
  logic [size-1:0]  grant_q, grant_d;
  logic [size-1:0]  done_q, done_d;
  logic             ch_req_q, ch_req_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [IDX_W-1:0] pick;
  logic             ack_s;

`ifdef HS_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  sync_ff #(
    .stages(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (ch_ack),
    .q  (ack_s)
  );

  // First asserted request at or after the pointer, wrapping at size-1.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [size-1:0]  req,
                                                input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] win;
    logic             found;
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < size; k++) begin
      idx = IDX_W'((int'(ptr) + k) % size);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign pick = rr_pick(req_vec, ptr_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    ch_req_d = ch_req_q;
    ptr_d    = ptr_q;
    winner_d = winner_q;
`ifdef HS_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        // ack_s must have returned to zero before a new 4-phase cycle may start.
        if ((|req_vec) && !ack_s) begin
          state_d  = REQ;
          winner_d = pick;
          grant_d  = {{(size-1){1'b0}}, 1'b1} << pick;
          ch_req_d = 1'b1;
`ifdef HS_ARB_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      REQ: begin
        if (ack_s) begin
          state_d  = RELEASE;
          ch_req_d = 1'b0;
        end
`ifdef HS_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(TIMEOUT)) begin
            state_d  = RELEASE;
            ch_req_d = 1'b0;
            err_d    = 1'b1;
          end
        end
`endif
      end
      RELEASE: begin
        if (!ack_s) begin
          state_d = IDLE;
          done_d  = grant_q;
          grant_d = '0;
          ptr_d   = (winner_q == LAST_IDX) ? '0 : winner_q + IDX_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        ch_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      ch_req_q <= 1'b0;
      ptr_q    <= '0;
      winner_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      ch_req_q <= ch_req_d;
      ptr_q    <= ptr_d;
      winner_q <= winner_d;
    end
  end

`ifdef HS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`endif

  assign grant_vec = grant_q;
  assign done_vec  = done_q;
  assign ch_req    = ch_req_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_handshake_arbiter.sv
// Directed bench for handshake_arbiter: size=2 and size=4 instances, each with an instantaneous channel model.
module tb_handshake_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] req2, grant2, done2;
  logic [3:0] req4, grant4, done4;
  logic       busy2, busy4, chreq2, chreq4, chack2, chack4;
  logic       ack_en2   = 1'b1;
  logic       force_hi2 = 1'b0;
`ifdef HS_ARB_TIMEOUT_EN
  logic       err2, err4;
`endif

  // Channel acknowledges as soon as it sees the request; force_hi2 models a channel stuck high.
  assign chack2 = force_hi2 | (chreq2 & ack_en2);
  assign chack4 = chreq4;

  handshake_arbiter #(.size(2), .SYNC_STAGES(2), .TIMEOUT(10)) dut2 (
    .clk(clk), .rst(rst), .req_vec(req2), .grant_vec(grant2), .done_vec(done2),
    .busy(busy2), .ch_req(chreq2), .ch_ack(chack2)
`ifdef HS_ARB_TIMEOUT_EN
    , .err_timeout(err2)
`endif
  );

  handshake_arbiter #(.size(4), .SYNC_STAGES(2), .TIMEOUT(10)) dut4 (
    .clk(clk), .rst(rst), .req_vec(req4), .grant_vec(grant4), .done_vec(done4),
    .busy(busy4), .ch_req(chreq4), .ch_ack(chack4)
`ifdef HS_ARB_TIMEOUT_EN
    , .err_timeout(err4)
`endif
  );

  logic       sel4 = 1'b0;
  logic [3:0] mon_grant, mon_done;
  logic       mon_busy, mon_chreq;
  assign mon_grant = sel4 ? grant4 : {2'b00, grant2};
  assign mon_done  = sel4 ? done4  : {2'b00, done2};
  assign mon_busy  = sel4 ? busy4  : busy2;
  assign mon_chreq = sel4 ? chreq4 : chreq2;

  logic [3:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req2 = '0;
    req4 = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One full transaction: wait for grant, pop expected winner, wait for the done pulse.
  task automatic serve_one(input bit drop, output int lat);
    int         waited;
    logic [3:0] exp;
    lat    = 0;
    waited = 0;
    while (mon_grant == 4'd0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("grant_seen", {31'd0, mon_grant != 4'd0}, 32'd1);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = 4'hf;
    check("grant", {28'd0, mon_grant}, {28'd0, exp});
    check("ch_req_with_grant", {31'd0, mon_chreq}, 32'd1);
    check("busy_with_grant", {31'd0, mon_busy}, 32'd1);
    if (drop) begin
      if (sel4) req4 = '0;
      else req2 = '0;
    end
    while (mon_done == 4'd0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("done", {28'd0, mon_done}, {28'd0, exp});
    check("grant_clear_at_done", {28'd0, mon_grant}, 32'd0);
    @(negedge clk);
    check("done_one_cycle", {28'd0, mon_done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst  = 1'b1;
    req2 = '0;
    req4 = '0;
    #1;
    check("rst_grant2", {30'd0, grant2}, 32'd0);
    check("rst_done2", {30'd0, done2}, 32'd0);
    check("rst_chreq2", {31'd0, chreq2}, 32'd0);
    check("rst_busy2", {31'd0, busy2}, 32'd0);
    check("rst_grant4", {28'd0, grant4}, 32'd0);
    check("rst_chreq4", {31'd0, chreq4}, 32'd0);
`ifdef HS_ARB_TIMEOUT_EN
    check("rst_err2", {31'd0, err2}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single requester: grant one cycle after request, done six cycles after grant.
    @(negedge clk);
    req2 = 2'b01;
    exp_q.push_back(4'b0001);
    @(negedge clk);
    check("first_grant_latency", {28'd0, mon_grant}, 32'd1);
    serve_one(1'b1, lat);
    check("txn_latency", lat, 32'd6);

    // Both requesting: strict alternation from pointer 0.
    do_reset();
    req2 = 2'b11;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    serve_one(1'b0, lat);
    serve_one(1'b0, lat);
    serve_one(1'b0, lat);
    serve_one(1'b1, lat);

    // size=4, requesters 1 and 3: order 1, 3, 1.
    do_reset();
    sel4 = 1'b1;
    req4 = 4'b1010;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    serve_one(1'b0, lat);
    serve_one(1'b0, lat);
    serve_one(1'b1, lat);
    sel4 = 1'b0;

    // Requester drops mid-transaction: still completes, busy returns low.
    do_reset();
    req2 = 2'b10;
    exp_q.push_back(4'b0010);
    serve_one(1'b1, lat);
    check("busy_after_drop", {31'd0, busy2}, 32'd0);

    // Reset in REQ while the channel is stuck high.
    do_reset();
    req2 = 2'b01;
    @(negedge clk);
    check("rr_grant_before_rst", {30'd0, grant2}, 32'd1);
    force_hi2 = 1'b1;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_chreq", {31'd0, chreq2}, 32'd0);
    check("midrst_grant", {30'd0, grant2}, 32'd0);
    check("midrst_busy", {31'd0, busy2}, 32'd0);
    req2 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_req_while_ack_high", {31'd0, chreq2}, 32'd0);
      if (i == 1) req2 = 2'b01;
    end
    force_hi2 = 1'b0;
    @(negedge clk);
    check("ack_fall_edge1", {31'd0, chreq2}, 32'd0);
    @(negedge clk);
    check("ack_fall_edge2", {31'd0, chreq2}, 32'd0);
    @(negedge clk);
    check("req_after_ack_low", {31'd0, chreq2}, 32'd1);
    exp_q.push_back(4'b0001);
    serve_one(1'b1, lat);

`ifdef HS_ARB_TIMEOUT_EN
    // Channel never acknowledges: abort after TIMEOUT cycles, then pointer advances.
    do_reset();
    ack_en2 = 1'b0;
    req2    = 2'b01;
    @(negedge clk);
    check("to_grant", {30'd0, grant2}, 32'd1);
    repeat (9) @(negedge clk);
    check("to_no_err_early", {31'd0, err2}, 32'd0);
    @(negedge clk);
    check("to_err_pulse", {31'd0, err2}, 32'd1);
    check("to_chreq_low", {31'd0, chreq2}, 32'd0);
    req2 = '0;
    @(negedge clk);
    check("to_done", {30'd0, done2}, 32'd1);
    check("to_err_one_cycle", {31'd0, err2}, 32'd0);
    ack_en2 = 1'b1;
    req2    = 2'b11;
    exp_q.push_back(4'b0010);
    serve_one(1'b1, lat);
`endif

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
